// File: rtl/seg7_pkg.sv
// Shared types and segment tables for the seven-segment scan decoder.
package seg7_pkg;

    localparam int unsigned CNT_W = 8;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low a..g patterns for hex 0..F, index equals the nibble value.
    localparam seg_t SEG_HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        TRK_IDLE  = 2'd0,
        TRK_TRACK = 2'd1,
        TRK_HELD  = 2'd2
    } seg7_trk_e;

    typedef struct packed {
        seg_t       seg;
        logic [3:0] an;
        logic       dp;
    } samp_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment encoding.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] nibble_c,
    output logic       legal_c,
    output logic       blank_c
);

    always_comb begin
        nibble_c = 4'd0;
        legal_c  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                nibble_c = 4'(i);
                legal_c  = 1'b1;
            end
        end
        blank_c = (seg == SEG_BLANK);
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs four hex digits from a multiplexed active-low 7-seg bus.
// Define SEG7_DEC_DP_EN to track and capture the decimal point.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] digit,
    output logic [3:0]  digit_vld,
    output logic [3:0]  digit_blank,
    output logic [3:0]  digit_err,
    output logic [3:0]  dp_out,
    output logic        an_err,
    output logic        upd
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    samp_t            s_q, tag_q;
    seg7_trk_e        state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             tag_ld, commit, one_low, multi_low;
    logic [1:0]       idx;
    logic [3:0]       nibble;
    logic             legal, blank;

    // Input sample register; dp is pinned high when not tracked so it never differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '1;
        end else begin
            s_q.seg <= seg;
            s_q.an  <= an;
`ifdef SEG7_DEC_DP_EN
            s_q.dp  <= dp;
`else
            s_q.dp  <= 1'b1;
`endif
        end
    end

    always_comb begin
        one_low = 1'b1;
        idx     = 2'd0;
        case (s_q.an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_low = 1'b0;
        endcase
        multi_low = !one_low && (s_q.an != 4'hF);
    end

    seg7_pattern_decode u_decode (
        .seg      (s_q.seg),
        .nibble_c (nibble),
        .legal_c  (legal),
        .blank_c  (blank)
    );

    // Tracker state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TRK_IDLE;
            cnt_q   <= '0;
            tag_q   <= '1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (tag_ld) tag_q <= s_q;
        end
    end

    // Next state: restart on any sample change, commit when the count reaches its limit.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        tag_ld    = 1'b0;
        commit    = 1'b0;
        if (!one_low) begin
            state_nxt = TRK_IDLE;
            cnt_nxt   = '0;
        end else if (state_q == TRK_IDLE || s_q != tag_q) begin
            tag_ld  = 1'b1;
            cnt_nxt = CNT_W'(1);
            if (CNT_MAX == CNT_W'(1)) begin
                commit    = 1'b1;
                state_nxt = TRK_HELD;
            end else begin
                state_nxt = TRK_TRACK;
            end
        end else if (state_q == TRK_TRACK) begin
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_nxt == CNT_MAX) begin
                commit    = 1'b1;
                state_nxt = TRK_HELD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit       <= '0;
            digit_vld   <= '0;
            digit_blank <= '0;
            digit_err   <= '0;
            an_err      <= 1'b0;
            upd         <= 1'b0;
        end else begin
            upd <= commit;
            if (multi_low) an_err <= 1'b1;
            if (commit) begin
                if (legal) digit[{idx, 2'b00} +: 4] <= nibble;
                digit_vld[idx]   <= legal;
                digit_blank[idx] <= blank;
                digit_err[idx]   <= ~(legal | blank);
            end
        end
    end

`ifdef SEG7_DEC_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_out <= '0;
        end else if (commit) begin
            dp_out[idx] <= ~s_q.dp;
        end
    end
`else
    logic unused_dp;
    assign unused_dp = dp;
    assign dp_out    = 4'b0000;
`endif

endmodule
